// File: rtl/note_sequencer.sv
// Tone-divider count generator: manual note select or an automatic Do..Do2 scale.
// Define NOTE_GAP_EN to insert GAP_CYCLES of silence between consecutive auto notes.
module note_sequencer #(
    parameter int unsigned NOTE_CYCLES = 25_000_000,
    parameter int unsigned GAP_CYCLES  = 2_500_000
) (
    input  logic        inclk,
    input  logic        Reset,
    input  logic [2:0]  sw_note,
    input  logic        manual_en,
    input  logic        start,
    input  logic        stop,
    output logic [31:0] div_clk_count,
    output logic [2:0]  note_idx,
    output logic        tone_en,
    output logic        playing,
    output logic        seq_done
);

    if (NOTE_CYCLES == 0 || GAP_CYCLES == 0) begin : g_param_check
        $error("note_sequencer: NOTE_CYCLES and GAP_CYCLES must be >= 1");
    end

`ifdef NOTE_GAP_EN
    typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_GAP} state_t;
`else
    typedef enum logic {ST_IDLE, ST_PLAY} state_t;
`endif

    // Half-period counts at 25 MHz effective toggle rate (25e6 / f, rounded)
    function automatic logic [31:0] note_period(input logic [2:0] idx);
        logic [31:0] p;
        case (idx)
            3'd0:    p = 32'd47801;
            3'd1:    p = 32'd42589;
            3'd2:    p = 32'd37936;
            3'd3:    p = 32'd35817;
            3'd4:    p = 32'd31928;
            3'd5:    p = 32'd28409;
            3'd6:    p = 32'd25329;
            default: p = 32'd23901;
        endcase
        return p;
    endfunction

    state_t      state_reg, state_next;
    logic [31:0] count_reg, count_next;
    logic [2:0]  idx_reg, idx_next;
    logic [31:0] div_reg;
    logic        tone_reg, tone_next;
    logic        playing_reg, playing_next;
    logic        done_reg, done_next;

    always_ff @(posedge inclk) begin
        if (!Reset) begin
            state_reg   <= ST_IDLE;
            count_reg   <= 32'd0;
            idx_reg     <= 3'd0;
            div_reg     <= 32'd47801;
            tone_reg    <= 1'b0;
            playing_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            idx_reg     <= idx_next;
            div_reg     <= note_period(idx_next);
            tone_reg    <= tone_next;
            playing_reg <= playing_next;
            done_reg    <= done_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        idx_next     = idx_reg;
        tone_next    = tone_reg;
        playing_next = playing_reg;
        done_next    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                idx_next     = sw_note;
                tone_next    = manual_en;
                playing_next = 1'b0;
                count_next   = 32'd0;
                if (start && !stop) begin
                    state_next   = ST_PLAY;
                    idx_next     = 3'd0;
                    count_next   = 32'd1;
                    playing_next = 1'b1;
                    tone_next    = 1'b1;
                end
            end

            ST_PLAY: begin
                tone_next  = 1'b1;
                count_next = count_reg + 32'd1;
                if (stop) begin
                    // Abort lands straight back on the manual outputs
                    state_next   = ST_IDLE;
                    idx_next     = sw_note;
                    tone_next    = manual_en;
                    playing_next = 1'b0;
                    count_next   = 32'd0;
                end else if (count_reg == NOTE_CYCLES) begin
                    if (idx_reg == 3'd7) begin
                        state_next   = ST_IDLE;
                        idx_next     = sw_note;
                        tone_next    = manual_en;
                        playing_next = 1'b0;
                        count_next   = 32'd0;
                        done_next    = 1'b1;
                    end else begin
`ifdef NOTE_GAP_EN
                        state_next = ST_GAP;
                        tone_next  = 1'b0;
                        count_next = 32'd1;
`else
                        idx_next   = idx_reg + 3'd1;
                        count_next = 32'd1;
`endif
                    end
                end
            end

`ifdef NOTE_GAP_EN
            ST_GAP: begin
                tone_next  = 1'b0;
                count_next = count_reg + 32'd1;
                if (stop) begin
                    state_next   = ST_IDLE;
                    idx_next     = sw_note;
                    tone_next    = manual_en;
                    playing_next = 1'b0;
                    count_next   = 32'd0;
                end else if (count_reg == GAP_CYCLES) begin
                    state_next = ST_PLAY;
                    idx_next   = idx_reg + 3'd1;
                    count_next = 32'd1;
                    tone_next  = 1'b1;
                end
            end
`endif

            default: begin
                state_next   = ST_IDLE;
                playing_next = 1'b0;
                count_next   = 32'd0;
            end
        endcase
    end

    assign div_clk_count = div_reg;
    assign note_idx      = idx_reg;
    assign tone_en       = tone_reg;
    assign playing       = playing_reg;
    assign seq_done      = done_reg;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: manual vectors from a table, auto/stop/reset sequences by hand.
module tb_note_sequencer;

    localparam int unsigned NC = 8;
    localparam int unsigned GC = 2;
`ifdef NOTE_GAP_EN
    localparam int unsigned PER = NC + GC;
    localparam int unsigned SEQ_END = 8 * NC + 7 * GC;
`else
    localparam int unsigned PER = NC;
    localparam int unsigned SEQ_END = 8 * NC;
`endif

    localparam logic [31:0] NOTE_TAB [8] = '{32'd47801, 32'd42589, 32'd37936, 32'd35817,
                                            32'd31928, 32'd28409, 32'd25329, 32'd23901};

    logic        inclk = 1'b0;
    logic        Reset = 1'b0;
    logic [2:0]  sw_note = 3'd0;
    logic        manual_en = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] div_clk_count;
    logic [2:0]  note_idx;
    logic        tone_en;
    logic        playing;
    logic        seq_done;

    int checks = 0;
    int errors = 0;

    always #5 inclk = ~inclk;

    note_sequencer #(.NOTE_CYCLES(NC), .GAP_CYCLES(GC)) dut (
        .inclk        (inclk),
        .Reset        (Reset),
        .sw_note      (sw_note),
        .manual_en    (manual_en),
        .start        (start),
        .stop         (stop),
        .div_clk_count(div_clk_count),
        .note_idx     (note_idx),
        .tone_en      (tone_en),
        .playing      (playing),
        .seq_done     (seq_done)
    );

    typedef struct {
        logic [2:0]  sw;
        logic        men;
        logic [2:0]  exp_idx;
        logic [31:0] exp_div;
        logic        exp_tone;
    } man_vec_t;

    man_vec_t man_vecs [10];

    task automatic tick();
        @(posedge inclk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected auto-mode outputs t cycles after the start edge (t < SEQ_END)
    task automatic check_play(input int t);
        int unsigned idx;
        logic        tone;
        idx  = t / PER;
        tone = ((t % PER) < NC);
        check($sformatf("t%0d note_idx", t), {29'd0, note_idx}, idx);
        check($sformatf("t%0d div_clk_count", t), div_clk_count, NOTE_TAB[idx]);
        check($sformatf("t%0d tone_en", t), {31'd0, tone_en}, {31'd0, tone});
        check($sformatf("t%0d playing", t), {31'd0, playing}, 32'd1);
        check($sformatf("t%0d seq_done", t), {31'd0, seq_done}, 32'd0);
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " div_clk_count"}, div_clk_count, 32'd47801);
        check({tag, " note_idx"}, {29'd0, note_idx}, 32'd0);
        check({tag, " tone_en"}, {31'd0, tone_en}, 32'd0);
        check({tag, " playing"}, {31'd0, playing}, 32'd0);
        check({tag, " seq_done"}, {31'd0, seq_done}, 32'd0);
    endtask

    initial begin
        int done_cnt;

        for (int i = 0; i < 8; i++) begin
            man_vecs[i] = '{sw: 3'(i), men: 1'b1, exp_idx: 3'(i), exp_div: NOTE_TAB[i], exp_tone: 1'b1};
        end
        man_vecs[8] = '{sw: 3'd5, men: 1'b0, exp_idx: 3'd5, exp_div: 32'd28409, exp_tone: 1'b0};
        man_vecs[9] = '{sw: 3'd2, men: 1'b0, exp_idx: 3'd2, exp_div: 32'd37936, exp_tone: 1'b0};

        // Reset held with random activity on the inputs
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sw_note   = 3'($urandom);
            manual_en = 1'($urandom);
            start     = 1'($urandom);
            stop      = 1'($urandom);
            tick();
        end
        check_reset_vals("reset");
        $display("reset: idx=%0d div=%0d tone=%0d", note_idx, div_clk_count, tone_en);
        start = 1'b0; stop = 1'b0; sw_note = 3'd0; manual_en = 1'b0;
        Reset = 1'b1;
        tick();

        // Manual sweep: each change visible one edge later, held 4 cycles
        for (int i = 0; i < 10; i++) begin
            sw_note   = man_vecs[i].sw;
            manual_en = man_vecs[i].men;
            tick();
            check($sformatf("man%0d note_idx", i), {29'd0, note_idx}, {29'd0, man_vecs[i].exp_idx});
            check($sformatf("man%0d div", i), div_clk_count, man_vecs[i].exp_div);
            check($sformatf("man%0d tone_en", i), {31'd0, tone_en}, {31'd0, man_vecs[i].exp_tone});
            check($sformatf("man%0d playing", i), {31'd0, playing}, 32'd0);
            $display("manual %0d: sw=%0d en=%0d -> div=%0d tone=%0d", i, sw_note, manual_en,
                     div_clk_count, tone_en);
            tick(); tick(); tick();
        end

        // Full auto sequence
        start_pulse();
        check_play(0);
        for (int t = 1; t < int'(SEQ_END); t++) begin
            tick();
            check_play(t);
        end
        tick();
        check("end seq_done", {31'd0, seq_done}, 32'd1);
        check("end playing", {31'd0, playing}, 32'd0);
        tick();
        check("post seq_done", {31'd0, seq_done}, 32'd0);
        check("post note_idx", {29'd0, note_idx}, 32'd2);
        check("post tone_en", {31'd0, tone_en}, 32'd0);
        $display("auto: seq_done seen at t=%0d", SEQ_END);

        // Stop during note 3
        start_pulse();
        for (int t = 1; t < int'(3 * PER + 2); t++) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop playing", {31'd0, playing}, 32'd0);
        check("stop note_idx", {29'd0, note_idx}, 32'd2);
        check("stop div", div_clk_count, 32'd37936);
        check("stop seq_done", {31'd0, seq_done}, 32'd0);
        done_cnt = 0;
        for (int t = 0; t < int'(SEQ_END); t++) begin
            tick();
            if (seq_done) done_cnt++;
        end
        check("stop no seq_done", done_cnt, 0);
        $display("stop: playing=%0d idx=%0d", playing, note_idx);

        // start and stop together while idle
        sw_note = 3'd4; manual_en = 1'b1;
        tick();
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check("startstop playing", {31'd0, playing}, 32'd0);
        check("startstop note_idx", {29'd0, note_idx}, 32'd4);
        check("startstop tone_en", {31'd0, tone_en}, 32'd1);
        tick();
        check("startstop playing2", {31'd0, playing}, 32'd0);
        $display("start+stop idle: playing=%0d idx=%0d", playing, note_idx);

        // Second start during note 5 is ignored; manual inputs ignored too
        start_pulse();
        check_play(0);
        for (int t = 1; t < int'(SEQ_END); t++) begin
            if (t == int'(5 * PER + 1)) begin
                start = 1'b1; sw_note = 3'd1; manual_en = 1'b0;
            end
            tick();
            start = 1'b0;
            check_play(t);
        end
        tick();
        check("restart seq_done", {31'd0, seq_done}, 32'd1);
        $display("ignored start: sequence completed at t=%0d", SEQ_END);

        // Reset during note 5
        tick();
        start_pulse();
        for (int t = 1; t < int'(5 * PER + 3); t++) tick();
        check("pre-reset note_idx", {29'd0, note_idx}, 32'd5);
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        check_reset_vals("midreset");
        manual_en = 1'b0;
        done_cnt = 0;
        for (int t = 0; t < int'(SEQ_END); t++) begin
            tick();
            if (seq_done || playing) done_cnt++;
        end
        check("midreset no activity", done_cnt, 0);
        $display("mid reset: idx=%0d playing=%0d", note_idx, playing);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
